// File: rtl/seq_alu.sv
// Sequential ALU with valid/ready handshakes, registered flags and multi-cycle MUL/DIV.
// Define SEQ_ALU_DIV_EN to build the restoring divider; otherwise op 9 acts as pass.
module seq_alu #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] result_hi,
    output logic             flag_z,
    output logic             flag_n,
    output logic             flag_c,
    output logic             flag_v,
    output logic             flag_dz
);

    localparam int SHW = $clog2(WIDTH);
    localparam int MSB = WIDTH - 1;

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_AND = 4'd2;
    localparam logic [3:0] OP_OR  = 4'd3;
    localparam logic [3:0] OP_XOR = 4'd4;
    localparam logic [3:0] OP_SLT = 4'd5;
    localparam logic [3:0] OP_SLL = 4'd6;
    localparam logic [3:0] OP_SRL = 4'd7;
    localparam logic [3:0] OP_MUL = 4'd8;
`ifdef SEQ_ALU_DIV_EN
    localparam logic [3:0] OP_DIV = 4'd9;
`endif

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MUL,
`ifdef SEQ_ALU_DIV_EN
        ST_DIV,
`endif
        ST_DONE
    } state_t;

    state_t state, state_nxt;

    logic                 accept;
    logic                 start_mul, start_div;
    logic [2*WIDTH-1:0]   acc;
    logic [WIDTH-1:0]     b_q;
    logic [SHW-1:0]       cnt;

    logic [WIDTH:0]       sum_ext, diff_ext;
    logic [WIDTH-1:0]     alu_res, alu_hi;
    logic                 alu_c, alu_v, alu_dz;

    logic [WIDTH:0]       mul_sum;
    logic [2*WIDTH-1:0]   mul_next;

    logic                 ld_en;
    logic [WIDTH-1:0]     ld_res, ld_hi;
    logic                 ld_c, ld_v, ld_dz;

    assign in_ready  = (state == ST_IDLE);
    assign out_valid = (state == ST_DONE);
    assign accept    = in_valid && in_ready;
    assign start_mul = (op == OP_MUL);
`ifdef SEQ_ALU_DIV_EN
    // A zero divisor takes the single-cycle path with the saturated result.
    assign start_div = (op == OP_DIV) && (b != '0);
`else
    assign start_div = 1'b0;
`endif

    // NOTE: sequential state is only ever written with non-blocking assignments.
    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    if (start_mul)      state_nxt = ST_MUL;
`ifdef SEQ_ALU_DIV_EN
                    else if (start_div) state_nxt = ST_DIV;
`endif
                    else                state_nxt = ST_DONE;
                end
            end
            ST_MUL:  if (cnt == '0) state_nxt = ST_DONE;
`ifdef SEQ_ALU_DIV_EN
            ST_DIV:  if (cnt == '0) state_nxt = ST_DONE;
`endif
            ST_DONE: if (out_ready) state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign sum_ext  = {1'b0, a} + {1'b0, b};
    assign diff_ext = {1'b0, a} - {1'b0, b};

    always_comb begin
        alu_res = a;
        alu_hi  = '0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        alu_dz  = 1'b0;
        case (op)
            OP_ADD: begin
                alu_res = sum_ext[WIDTH-1:0];
                alu_c   = sum_ext[WIDTH];
                alu_v   = (a[MSB] == b[MSB]) && (sum_ext[MSB] != a[MSB]);
            end
            OP_SUB: begin
                alu_res = diff_ext[WIDTH-1:0];
                alu_c   = diff_ext[WIDTH];
                alu_v   = (a[MSB] != b[MSB]) && (diff_ext[MSB] != a[MSB]);
            end
            OP_AND: alu_res = a & b;
            OP_OR:  alu_res = a | b;
            OP_XOR: alu_res = a ^ b;
            OP_SLT: alu_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            OP_SLL: alu_res = a << b[SHW-1:0];
            OP_SRL: alu_res = a >> b[SHW-1:0];
`ifdef SEQ_ALU_DIV_EN
            OP_DIV: begin
                alu_res = '1;
                alu_hi  = a;
                alu_dz  = 1'b1;
            end
`endif
            default: ;
        endcase
    end

    // acc = {partial product high, multiplier being shifted out}.
    assign mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, b_q} : '0);
    assign mul_next = {mul_sum, acc[WIDTH-1:1]};

`ifdef SEQ_ALU_DIV_EN
    logic [WIDTH:0]     div_shift, div_diff;
    logic [2*WIDTH-1:0] div_next;

    // acc = {remainder, dividend bits shifting into the quotient}.
    assign div_shift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    assign div_diff  = div_shift - {1'b0, b_q};
    assign div_next  = div_diff[WIDTH]
                     ? {div_shift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0}
                     : {div_diff[WIDTH-1:0],  acc[WIDTH-2:0], 1'b1};
`endif

    always_comb begin
        ld_en  = 1'b0;
        ld_res = alu_res;
        ld_hi  = alu_hi;
        ld_c   = alu_c;
        ld_v   = alu_v;
        ld_dz  = alu_dz;
        case (state)
            ST_IDLE: ld_en = accept && !start_mul && !start_div;
            ST_MUL: begin
                ld_en = (cnt == '0);
                {ld_hi, ld_res} = mul_next;
                ld_c  = 1'b0;
                ld_v  = 1'b0;
                ld_dz = 1'b0;
            end
`ifdef SEQ_ALU_DIV_EN
            ST_DIV: begin
                ld_en  = (cnt == '0);
                ld_res = div_next[WIDTH-1:0];
                ld_hi  = div_next[2*WIDTH-1:WIDTH];
                ld_c   = 1'b0;
                ld_v   = 1'b0;
                ld_dz  = 1'b0;
            end
`endif
            default: ;
        endcase
    end

    // NOTE: the accumulator is reset too, so an aborted MUL/DIV leaves no residue.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc       <= '0;
            b_q       <= '0;
            cnt       <= '0;
            result    <= '0;
            result_hi <= '0;
            flag_z    <= 1'b0;
            flag_n    <= 1'b0;
            flag_c    <= 1'b0;
            flag_v    <= 1'b0;
            flag_dz   <= 1'b0;
        end else begin
            if (state == ST_IDLE && accept && (start_mul || start_div)) begin
                acc <= {{WIDTH{1'b0}}, a};
                b_q <= b;
                cnt <= SHW'(WIDTH - 1);
            end else if (state == ST_MUL) begin
                acc <= mul_next;
                cnt <= cnt - SHW'(1);
            end
`ifdef SEQ_ALU_DIV_EN
            else if (state == ST_DIV) begin
                acc <= div_next;
                cnt <= cnt - SHW'(1);
            end
`endif
            if (ld_en) begin
                result    <= ld_res;
                result_hi <= ld_hi;
                flag_z    <= (ld_res == '0);
                flag_n    <= ld_res[MSB];
                flag_c    <= ld_c;
                flag_v    <= ld_v;
                flag_dz   <= ld_dz;
            end
        end
    end

endmodule
